riscv_multicycle_datapath: RTL and testbench

//  Multi-cycle RV32I subset core: datapath plus main FSM controller, one unified instr/data memory port.

---
 rtl/riscv_multicycle_datapath.sv | 227 ++++++++++++++++++++++
 tb/tb_riscv_multicycle_datapath.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_datapath.sv
// riscv_multicycle_datapath: multi-cycle RV32I subset core (lw, sw, add/sub/and/or/xor/slt,
// addi/andi/ori/xori/slti, beq/bne, jal) with one shared instruction/data memory port.
// Illegal opcodes/funct3 and misaligned accesses or targets trap and halt until reset.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_RST      | first cycle after reset release, launches the first fetch
// S_FETCH    | instruction read in flight, waits for mem_ready
// S_DECODE   | read rs1/rs2, precompute branch target, dispatch on opcode
// S_MEMADR   | effective address for lw/sw, alignment check
// S_MEMREAD  | load read in flight
// S_MEMWRITE | store write in flight, retires on mem_ready
// S_MEMWB    | load data written to rd
// S_EXECR    | register-register ALU operation
// S_EXECI    | register-immediate ALU operation
// S_ALUWB    | ALU result (or jal link address) written to rd
// S_BRANCH   | beq/bne compare and redirect
// S_JAL      | jump target check and redirect
// S_TRAP     | halted at the faulting instruction, only reset leaves
module riscv_multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              a_rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              retire,
  output logic              halted,
  output logic [31:0]       pc_o
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;

  state_t      state;
  logic [31:0] pc, old_pc, instr, a_reg, b_reg, alu_out, data_reg;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_res, addr_calc, jal_target, wb_data;
  logic        alu_f3_ok, br_taken, rf_we;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf[rs2];

  // funct3 codes implemented by both R-type and I-type ALU groups
  assign alu_f3_ok  = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
                      (f3 == 3'b110) || (f3 == 3'b111);
  assign addr_calc  = a_reg + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign jal_target = old_pc + imm_j;
  assign br_taken   = (f3 == 3'b000) ? (a_reg == b_reg) : (a_reg != b_reg);

  assign rf_we   = ((state == S_ALUWB) || (state == S_MEMWB)) && (rd != 5'd0);
  assign wb_data = (state == S_MEMWB) ? data_reg : alu_out;
  assign pc_o    = pc;

  // ALU shared by the R-type and I-type execute states; funct7 only matters for add/sub
  always_comb begin
    alu_b   = (state == S_EXECI) ? imm_i : b_reg;
    alu_res = 32'h0;
    case (f3)
      3'b000:  alu_res = ((state == S_EXECR) && instr[30]) ? a_reg - alu_b : a_reg + alu_b;
      3'b010:  alu_res = {31'h0, ($signed(a_reg) < $signed(alu_b))};
      3'b100:  alu_res = a_reg ^ alu_b;
      3'b110:  alu_res = a_reg | alu_b;
      3'b111:  alu_res = a_reg & alu_b;
      default: alu_res = 32'h0;
    endcase
  end

  // Register bank write port; x0 is never written and is forced to read zero above
  always_ff @(posedge clk) begin
    if (rf_we) rf[rd] <= wb_data;
  end

  // Main controller: state, datapath registers and registered memory/status outputs
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state     <= S_RST;
      pc        <= RESET_PC;
      old_pc    <= RESET_PC;
      instr     <= 32'h0;
      a_reg     <= 32'h0;
      b_reg     <= 32'h0;
      alu_out   <= 32'h0;
      data_reg  <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= ADDR_W'(RESET_PC);
      mem_wdata <= 32'h0;
      retire    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_RST: begin
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= ADDR_W'(pc);
        end
        S_FETCH: begin
          if (mem_ready) begin
            instr   <= mem_rdata;
            old_pc  <= pc;
            pc      <= pc + 32'd4;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg   <= rs1_val;
          b_reg   <= rs2_val;
          alu_out <= old_pc + imm_b;
          case (opcode)
            OP_LOAD, OP_STORE: state <= (f3 == 3'b010) ? S_MEMADR : S_TRAP;
            OP_R:              state <= alu_f3_ok ? S_EXECR : S_TRAP;
            OP_I:              state <= alu_f3_ok ? S_EXECI : S_TRAP;
            OP_BR:             state <= (f3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
            OP_JAL:            state <= S_JAL;
            default:           state <= S_TRAP;
          endcase
        end
        S_MEMADR: begin
          alu_out <= addr_calc;
          if (addr_calc[1:0] != 2'b00) begin
            state <= S_TRAP;
          end else begin
            mem_req   <= 1'b1;
            mem_addr  <= ADDR_W'(addr_calc);
            mem_we    <= (opcode == OP_STORE);
            mem_wdata <= b_reg;
            state     <= (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
          end
        end
        S_MEMREAD: begin
          if (mem_ready) begin
            data_reg <= mem_rdata;
            mem_req  <= 1'b0;
            state    <= S_MEMWB;
          end
        end
        S_MEMWRITE: begin
          // the next fetch is issued straight away, so mem_req stays high with new attributes
          if (mem_ready) begin
            retire   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= ADDR_W'(pc);
            state    <= S_FETCH;
          end
        end
        S_EXECR, S_EXECI: begin
          alu_out <= alu_res;
          state   <= S_ALUWB;
        end
        S_ALUWB, S_MEMWB: begin
          retire   <= 1'b1;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= ADDR_W'(pc);
          state    <= S_FETCH;
        end
        S_BRANCH: begin
          if (br_taken && alu_out[1]) begin
            state <= S_TRAP;
          end else begin
            retire  <= 1'b1;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            state   <= S_FETCH;
            if (br_taken) begin
              pc       <= alu_out;
              mem_addr <= ADDR_W'(alu_out);
            end else begin
              mem_addr <= ADDR_W'(pc);
            end
          end
        end
        S_JAL: begin
          if (jal_target[1]) begin
            state <= S_TRAP;
          end else begin
            pc      <= jal_target;
            alu_out <= old_pc + 32'd4;
            state   <= S_ALUWB;
          end
        end
        S_TRAP: begin
          halted  <= 1'b1;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          pc      <= old_pc;
        end
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_datapath.sv
// Bench for riscv_multicycle_datapath: a memory responder with programmable wait states,
// and scoreboards of expected retires (next PC and cycle latency) and expected stores.
module tb_riscv_multicycle_datapath;

  logic        clk;
  logic        a_rst;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;

  riscv_multicycle_datapath #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk(clk), .a_rst(a_rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .retire(retire), .halted(halted), .pc_o(pc_o)
  );

  typedef struct { logic [31:0] pc; int lat; } ret_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;

  ret_t        retire_q[$];
  st_t         store_q[$];
  logic [31:0] mem [256];
  int          n_chk = 0;
  int          n_fail = 0;
  int          fetch_wait = 0;
  int          data_wait = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  bit          first_retire = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask
  task automatic exp_ret(input logic [31:0] pc, input int lat);
    ret_t r;
    r.pc = pc; r.lat = lat;
    retire_q.push_back(r);
  endtask
  task automatic exp_st(input logic [31:0] a, input logic [31:0] d);
    st_t s;
    s.addr = a; s.data = d;
    store_q.push_back(s);
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  // memory responder: ready after a programmed number of wait cycles, checks every store
  initial begin
    int   wcnt;
    int   wt;
    st_t  s;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req && !a_rst) begin
        wt = (mem_addr >= 32'h100) ? data_wait : fetch_wait;
        if (wcnt >= wt) begin
          mem_ready = 1'b1;
          wcnt = 0;
          if (mem_we) begin
            mem[mem_addr[9:2]] = mem_wdata;
            if (store_q.size() == 0) begin
              chk("unexpected_store", 32'(mem_we), 32'h0);
            end else begin
              s = store_q.pop_front();
              chk("store_addr", mem_addr, s.addr);
              chk("store_data", mem_wdata, s.data);
            end
          end else begin
            mem_rdata = mem[mem_addr[9:2]];
          end
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // retire monitor: next PC and cycles since the previous retire
  initial begin
    ret_t r;
    forever begin
      @(negedge clk);
      if (retire) begin
        if (retire_q.size() == 0) begin
          chk("unexpected_retire", 32'(retire), 32'h0);
        end else begin
          r = retire_q.pop_front();
          chk("retire_pc", pc_o, r.pc);
          if (!first_retire) chk("retire_latency", 32'(cyc - last_cyc), 32'(r.lat));
          first_retire = 0;
          last_cyc = cyc;
        end
      end
    end
  end

  task automatic do_reset();
    a_rst = 1'b1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_retire", 32'(retire), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    repeat (2) @(negedge clk);
    first_retire = 1;
    a_rst = 1'b0;
  endtask

  task automatic wait_halt(input logic [31:0] exp_pc);
    int n;
    int bad;
    n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("halted", 32'(halted), 32'h1);
    chk("halt_pc", pc_o, exp_pc);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req || retire) bad++;
    end
    chk("halt_quiet", 32'(bad), 32'h0);
    chk("retire_q_left", 32'(retire_q.size()), 32'h0);
    chk("store_q_left", 32'(store_q.size()), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    a_rst = 1'b1;

    // run A: zero-wait ALU, stores, jal, branches, x0 handling, illegal opcode halt
    clear_mem();
    fetch_wait = 0; data_wait = 0;
    put(32'h00, enc_i(7'h13, 5'd1, 3'b000, 5'd0, 32'd5));          exp_ret(32'h04, 4);
    put(32'h04, enc_i(7'h13, 5'd2, 3'b000, 5'd0, 32'hFFFF_FFFD));  exp_ret(32'h08, 4);
    put(32'h08, enc_r(7'h00, 5'd3, 3'b000, 5'd1, 5'd2));           exp_ret(32'h0C, 4);
    put(32'h0C, enc_s(5'd3, 5'd0, 32'd256));  exp_st(32'd256, 32'd2); exp_ret(32'h10, 4);
    put(32'h10, enc_j(5'd5, 32'd8));                                exp_ret(32'h18, 4);
    put(32'h14, 32'h0000_007F);
    put(32'h18, enc_i(7'h13, 5'd0, 3'b000, 5'd0, 32'd7));          exp_ret(32'h1C, 4);
    put(32'h1C, enc_r(7'h00, 5'd4, 3'b000, 5'd0, 5'd0));           exp_ret(32'h20, 4);
    put(32'h20, enc_r(7'h20, 5'd6, 3'b000, 5'd1, 5'd2));           exp_ret(32'h24, 4);
    put(32'h24, enc_r(7'h00, 5'd7, 3'b010, 5'd2, 5'd1));           exp_ret(32'h28, 4);
    put(32'h28, enc_s(5'd5, 5'd0, 32'd260)); exp_st(32'd260, 32'h14); exp_ret(32'h2C, 4);
    put(32'h2C, enc_s(5'd4, 5'd0, 32'd264)); exp_st(32'd264, 32'd0);  exp_ret(32'h30, 4);
    put(32'h30, enc_s(5'd6, 5'd0, 32'd268)); exp_st(32'd268, 32'd8);  exp_ret(32'h34, 4);
    put(32'h34, enc_s(5'd7, 5'd0, 32'd272)); exp_st(32'd272, 32'd1);  exp_ret(32'h38, 4);
    put(32'h38, enc_b(3'b001, 5'd1, 5'd2, 32'd8));                  exp_ret(32'h40, 3);
    put(32'h3C, 32'h0000_007F);
    put(32'h40, enc_b(3'b000, 5'd1, 5'd2, 32'd8));                  exp_ret(32'h44, 3);
    put(32'h44, enc_i(7'h13, 5'd10, 3'b000, 5'd0, 32'd2));         exp_ret(32'h48, 4);
    put(32'h48, enc_i(7'h13, 5'd10, 3'b000, 5'd10, 32'hFFFF_FFFF)); exp_ret(32'h4C, 4);
    put(32'h4C, enc_b(3'b001, 5'd10, 5'd0, 32'hFFFF_FFFC));         exp_ret(32'h48, 3);
    exp_ret(32'h4C, 4);
    exp_ret(32'h50, 3);
    put(32'h50, enc_i(7'h13, 5'd11, 3'b100, 5'd1, 32'h0F));        exp_ret(32'h54, 4);
    put(32'h54, enc_s(5'd11, 5'd0, 32'd276)); exp_st(32'd276, 32'd10); exp_ret(32'h58, 4);
    put(32'h58, 32'h0000_007F);
    do_reset();
    wait_halt(32'h58);

    // run B: load/store with three data wait cycles, then misaligned load halt
    clear_mem();
    fetch_wait = 0; data_wait = 3;
    put(32'h100, 32'hDEAD_BEEF);
    put(32'h00, enc_i(7'h13, 5'd1, 3'b000, 5'd0, 32'd1));          exp_ret(32'h04, 4);
    put(32'h04, enc_i(7'h03, 5'd11, 3'b010, 5'd0, 32'd256));       exp_ret(32'h08, 8);
    put(32'h08, enc_s(5'd11, 5'd0, 32'd260)); exp_st(32'd260, 32'hDEAD_BEEF); exp_ret(32'h0C, 7);
    put(32'h0C, enc_i(7'h03, 5'd12, 3'b010, 5'd0, 32'd258));
    do_reset();
    wait_halt(32'h0C);

    // run C: reset asserted while a fetch waits for ready, then a clean restart
    clear_mem();
    fetch_wait = 30; data_wait = 0;
    put(32'h00, enc_i(7'h13, 5'd1, 3'b000, 5'd0, 32'd9));          exp_ret(32'h04, 4);
    put(32'h04, enc_s(5'd1, 5'd0, 32'd256)); exp_st(32'd256, 32'd9); exp_ret(32'h08, 4);
    do_reset();
    repeat (5) @(negedge clk);
    chk("fetch_waiting_req", 32'(mem_req), 32'h1);
    chk("fetch_waiting_pc", pc_o, 32'h0);
    @(posedge clk);
    #2;
    fetch_wait = 0;
    do_reset();
    wait_halt(32'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
